// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the pipeline run-control sequencer.
// The state encodings and the drain-length helper live here so the FSM and
// any tooling that decodes the state agree on one definition.
package pipeline_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_RUN    = 3'd1,
        SEQ_STEP   = 3'd2,
        SEQ_DRAIN  = 3'd3,
        SEQ_HALTED = 3'd4
    } seq_state_t;

    // Instructions still in flight behind a HALT: ID/EX through MEM/WB.
    function automatic int unsigned drain_len(input int unsigned nb_stages);
        return nb_stages - 2;
    endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Run-control bundle between the debug/hazard units and the sequencer.
// master: debug unit + hazard unit side (drives commands, reads controls).
// slave:  the sequencer (reads commands, drives pipeline controls).
interface pipeline_sequencer_if;

    logic i_start;
    logic i_step;
    logic i_stop;
    logic i_clear;
    logic i_not_load;
    logic i_halt;
    logic o_pc_en;
    logic o_if_id_en;
    logic o_id_ex_bubble;
    logic o_back_en;
    logic o_flush;
    logic o_running;
    logic o_halted;
    logic o_step_done;

    modport master (
        output i_start, i_step, i_stop, i_clear, i_not_load, i_halt,
        input  o_pc_en, o_if_id_en, o_id_ex_bubble, o_back_en,
               o_flush, o_running, o_halted, o_step_done
    );

    modport slave (
        input  i_start, i_step, i_stop, i_clear, i_not_load, i_halt,
        output o_pc_en, o_if_id_en, o_id_ex_bubble, o_back_en,
               o_flush, o_running, o_halted, o_step_done
    );

endinterface

// File: rtl/pipe_seq_cycle_counter.sv
// Saturating executed-cycle counter. Clear has priority over increment;
// the count sticks at all-ones instead of wrapping.
module pipe_seq_cycle_counter #(
    parameter int unsigned NB_CYCLES = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_inc,
    output logic [NB_CYCLES-1:0] o_count
);

    // Count advancing cycles, holding at the top value.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_count <= '0;
        end else if (i_clear) begin
            o_count <= '0;
        end else if (i_inc && (o_count != '1)) begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Run-control sequencer for the 5-stage MIPS pipeline.
// Merges debug run/step/stop/clear with hazard stall/halt requests and
// drives the per-stage enables, ID/EX bubble and flush. After a HALT the
// back end drains NB_STAGES-2 cycles before reporting halted.
// Optional feature: define PIPE_SEQ_CYCLE_COUNT_EN to add o_cycle_count.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int unsigned NB_STAGES = 5,
    parameter int unsigned NB_CYCLES = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
`ifdef PIPE_SEQ_CYCLE_COUNT_EN
    output logic [NB_CYCLES-1:0] o_cycle_count,
`endif
    pipeline_sequencer_if.slave  seq_if
);

    localparam int unsigned DW = $clog2(NB_STAGES);
    localparam logic [DW-1:0] DRAIN_LEN = DW'(drain_len(NB_STAGES));

    if (NB_STAGES < 3) begin : g_bad_depth
        $error("pipeline_sequencer: NB_STAGES must be at least 3");
    end

    seq_state_t    state;
    seq_state_t    state_next;
    logic [DW-1:0] drain_cnt;
    logic          drain_load;
    logic          step_done_q;

    logic pc_en;
    logic if_id_en;
    logic id_ex_bubble;
    logic back_en;
    logic flush;
    logic running;
    logic halted;

    // State register and the registered step-complete pulse.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state       <= SEQ_IDLE;
            step_done_q <= 1'b0;
        end else begin
            state       <= state_next;
            step_done_q <= (state == SEQ_STEP);
        end
    end

    // Drain counter: loaded when HALT is accepted, counts down through DRAIN.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            drain_cnt <= '0;
        end else if (drain_load) begin
            drain_cnt <= DRAIN_LEN;
        end else if (state == SEQ_DRAIN) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Next-state and pipeline control decode.
    always_comb begin
        state_next   = state;
        drain_load   = 1'b0;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b0;
        back_en      = 1'b0;
        flush        = 1'b0;
        running      = 1'b0;
        halted       = 1'b0;

        case (state)
            SEQ_IDLE: begin
                if (seq_if.i_start) begin
                    state_next = SEQ_RUN;
                end else if (seq_if.i_step) begin
                    state_next = SEQ_STEP;
                end
            end

            SEQ_RUN, SEQ_STEP: begin
                running = (state == SEQ_RUN);
                back_en = 1'b1;
                // HALT is latched into IF/ID but replaced by a bubble in
                // ID/EX, so it never reaches EX; it outranks a stall.
                if (seq_if.i_halt) begin
                    if_id_en     = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (seq_if.i_not_load) begin
                    id_ex_bubble = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                end

                if (seq_if.i_halt) begin
                    state_next = SEQ_DRAIN;
                    drain_load = 1'b1;
                end else if (state == SEQ_STEP || seq_if.i_stop) begin
                    state_next = SEQ_IDLE;
                end
            end

            SEQ_DRAIN: begin
                back_en      = 1'b1;
                id_ex_bubble = 1'b1;
                if (drain_cnt == DW'(1)) begin
                    state_next = SEQ_HALTED;
                end
            end

            SEQ_HALTED: begin
                halted = 1'b1;
                if (seq_if.i_clear) begin
                    flush      = 1'b1;
                    state_next = SEQ_IDLE;
                end
            end

            default: state_next = SEQ_IDLE;
        endcase
    end

    assign seq_if.o_pc_en        = pc_en;
    assign seq_if.o_if_id_en     = if_id_en;
    assign seq_if.o_id_ex_bubble = id_ex_bubble;
    assign seq_if.o_back_en      = back_en;
    assign seq_if.o_flush        = flush;
    assign seq_if.o_running      = running;
    assign seq_if.o_halted       = halted;
    assign seq_if.o_step_done    = step_done_q;

`ifdef PIPE_SEQ_CYCLE_COUNT_EN
    pipe_seq_cycle_counter #(
        .NB_CYCLES (NB_CYCLES)
    ) u_cycle_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (seq_if.i_clear),
        .i_inc   (back_en),
        .o_count (o_cycle_count)
    );
`endif

endmodule
